mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_starve_ctr.sv | 28 ++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_I,
    WAIT_D
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam logic [3:0] WE_READ = 4'b0000;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive fetch-port arbitration losses.
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign limit_hit = (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between fetch (I) and load/store (D) ports.
// Optional grant statistics outputs are enabled with `define MEM_ARBITER_STATS_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic [3:0]    d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          m_req,
  output logic [3:0]    m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0]   stat_i_grants,
  output logic [31:0]   stat_d_grants,
  output logic [31:0]   stat_starve_forced
`endif
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);

  arb_state_t       state, state_next;
  arb_owner_t       owner;
  logic [LAT_W-1:0] lat_cnt, lat_next;
  logic [31:0]      i_rdata_q, d_rdata_q;
  logic             starve_hit;

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .inc       (d_gnt && i_req),
    .clr       (i_gnt),
    .limit_hit (starve_hit)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    lat_next   = lat_cnt;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && (starve_hit || !d_req)) begin
          i_gnt      = 1'b1;
          state_next = WAIT_I;
          lat_next   = LAT_INIT;
        end else if (d_req) begin
          d_gnt = 1'b1;
          if (d_we == WE_READ) begin
            state_next = WAIT_D;
            lat_next   = LAT_INIT;
          end
        end
      end
      WAIT_I, WAIT_D: begin
        if (lat_cnt == '0) begin
          i_rvalid   = (state == WAIT_I);
          d_rvalid   = (state == WAIT_D);
          state_next = IDLE;
        end else begin
          lat_next = lat_cnt - LAT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    // Reset suppresses grants and any read that was in flight.
    if (reset) begin
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
    end
  end

  always_comb begin
    owner   = d_gnt ? OWN_D : OWN_I;
    m_req   = i_gnt || d_gnt;
    m_we    = WE_READ;
    m_addr  = '0;
    m_wdata = '0;
    if (m_req) begin
      case (owner)
        OWN_D: begin
          m_we    = d_we;
          m_addr  = d_addr;
          m_wdata = d_wdata;
        end
        default: m_addr = i_addr;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_next;
      if (i_rvalid) i_rdata_q <= m_rdata;
      if (d_rvalid) d_rdata_q <= m_rdata;
    end
  end

  // Read data is visible in the rvalid cycle itself, then held.
  assign i_rdata = i_rvalid ? m_rdata : i_rdata_q;
  assign d_rdata = d_rvalid ? m_rdata : d_rdata_q;

`ifdef MEM_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_i_grants      <= '0;
      stat_d_grants      <= '0;
      stat_starve_forced <= '0;
    end else begin
      if (i_gnt) stat_i_grants <= stat_i_grants + 32'd1;
      if (d_gnt) stat_d_grants <= stat_d_grants + 32'd1;
      if (i_gnt && starve_hit && d_req) stat_starve_forced <= stat_starve_forced + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-1 instance with a byte-writable memory
// model and a latency-3 instance used for latency and mid-read reset checks.
module tb_mem_arbiter;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset, reset3;
  logic          i_req, d_req, i_req3, d_req3;
  logic [AW-1:0] i_addr, d_addr;
  logic [3:0]    d_we;
  logic [31:0]   d_wdata;

  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, m_req;
  logic [31:0]   i_rdata, d_rdata, m_wdata, m_rdata;
  logic [3:0]    m_we;
  logic [AW-1:0] m_addr;

  logic          i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, m_req3;
  logic [31:0]   i_rdata3, d_rdata3, m_wdata3;
  logic [3:0]    m_we3;
  logic [AW-1:0] m_addr3;

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] stat_i_grants, stat_d_grants, stat_starve_forced;
  logic [31:0] stat_i_grants3, stat_d_grants3, stat_starve_forced3;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4), .AW(AW)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef MEM_ARBITER_STATS_EN
    , .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
    .stat_starve_forced(stat_starve_forced)
`endif
  );

  mem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4), .AW(AW)) u_dut3 (
    .clk(clk), .reset(reset3),
    .i_req(i_req3), .i_addr(i_addr), .i_gnt(i_gnt3), .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
    .d_req(d_req3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .m_req(m_req3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(32'hDEAD_BEEF)
`ifdef MEM_ARBITER_STATS_EN
    , .stat_i_grants(stat_i_grants3), .stat_d_grants(stat_d_grants3),
    .stat_starve_forced(stat_starve_forced3)
`endif
  );

  // Latency-1 memory: 256 words, byte-enabled writes, preloaded while reset is high.
  logic [31:0] mem [256];
  logic [7:0]  rd_idx;

  always @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < 256; j++) mem[j] <= '0;
      mem[8'h40] <= 32'h1111_2222;
      mem[8'h80] <= 32'h3333_4444;
      mem[8'h10] <= 32'h0102_0304;
      rd_idx     <= '0;
    end else if (m_req) begin
      if (m_we == 4'b0000) begin
        rd_idx <= m_addr[9:2];
      end else begin
        for (int b = 0; b < 4; b++)
          if (m_we[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      end
    end
  end

  assign m_rdata = mem[rd_idx];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; reset3 = 1'b1;
    i_req = 1'b0; d_req = 1'b0; i_req3 = 1'b0; d_req3 = 1'b0;
    i_addr = '0; d_addr = '0; d_we = 4'b0000; d_wdata = '0;

    // Reset gating of grants
    next_cycle(); i_req = 1'b1; i_req3 = 1'b1; settle();
    check("rst_i_gnt", 32'(i_gnt), 32'd0);
    check("rst_m_req", 32'(m_req), 32'd0);
    check("rst_i_gnt3", 32'(i_gnt3), 32'd0);

    // First cycle out of reset, no requests
    next_cycle(); reset = 1'b0; reset3 = 1'b0; i_req = 1'b0; i_req3 = 1'b0; settle();
    check("post_rst_m_req", 32'(m_req), 32'd0);
    check("post_rst_i_rdata", i_rdata, 32'd0);
    check("post_rst_d_rdata", d_rdata, 32'd0);

    // I read alone
    next_cycle(); i_req = 1'b1; i_addr = 32'h100; settle();
    check("iread_gnt", 32'(i_gnt), 32'd1);
    check("iread_m_req", 32'(m_req), 32'd1);
    check("iread_m_addr", m_addr, 32'h100);
    check("iread_m_we", 32'(m_we), 32'd0);
    next_cycle(); i_req = 1'b0; settle();
    check("iread_rvalid", 32'(i_rvalid), 32'd1);
    check("iread_rdata", i_rdata, 32'h1111_2222);
    check("iread_no_gnt_wait", 32'(i_gnt), 32'd0);
    next_cycle(); i_req = 1'b1; settle();
    check("iread_rvalid_pulse", 32'(i_rvalid), 32'd0);
    check("iread_rdata_hold", i_rdata, 32'h1111_2222);
    check("iread_regnt", 32'(i_gnt), 32'd1);
    next_cycle(); i_req = 1'b0; settle();
    check("iread2_rvalid", 32'(i_rvalid), 32'd1);

    // Simultaneous requests: D wins, I follows
    next_cycle(); i_req = 1'b1; d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h200; settle();
    check("sim_d_gnt", 32'(d_gnt), 32'd1);
    check("sim_i_gnt", 32'(i_gnt), 32'd0);
    check("sim_m_addr", m_addr, 32'h200);
    next_cycle(); d_req = 1'b0; settle();
    check("sim_d_rvalid", 32'(d_rvalid), 32'd1);
    check("sim_d_rdata", d_rdata, 32'h3333_4444);
    check("sim_i_gnt_wait", 32'(i_gnt), 32'd0);
    next_cycle(); settle();
    check("sim_i_gnt_late", 32'(i_gnt), 32'd1);
    check("sim_d_rdata_hold", d_rdata, 32'h3333_4444);
    next_cycle(); i_req = 1'b0; settle();
    check("sim_i_rvalid", 32'(i_rvalid), 32'd1);
    check("sim_i_rdata", i_rdata, 32'h1111_2222);

    // Starvation guard from a fresh reset
    next_cycle(); reset = 1'b1; settle();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      reset = 1'b0; i_req = 1'b1; i_addr = 32'h100;
      d_req = 1'b1; d_we = 4'b1111; d_addr = 32'h300; d_wdata = 32'(k);
      settle();
      check($sformatf("starve_d_gnt%0d", k), 32'(d_gnt), 32'd1);
      check($sformatf("starve_i_gnt%0d", k), 32'(i_gnt), 32'd0);
    end
    next_cycle(); settle();
    check("starve_forced_i_gnt", 32'(i_gnt), 32'd1);
    check("starve_forced_d_gnt", 32'(d_gnt), 32'd0);
    check("starve_forced_m_we", 32'(m_we), 32'd0);
    check("starve_forced_m_addr", m_addr, 32'h100);
    next_cycle(); settle();
    check("starve_i_rvalid", 32'(i_rvalid), 32'd1);
    check("starve_d_blocked", 32'(d_gnt), 32'd0);
`ifdef MEM_ARBITER_STATS_EN
    check("stat_d_grants", stat_d_grants, 32'd4);
    check("stat_i_grants", stat_i_grants, 32'd1);
    check("stat_starve_forced", stat_starve_forced, 32'd1);
`endif
    next_cycle(); settle();
    check("starve_clr_d_wins", 32'(d_gnt), 32'd1);
    check("starve_clr_i_loses", 32'(i_gnt), 32'd0);
    next_cycle(); d_req = 1'b0; settle();
    check("starve_i_after", 32'(i_gnt), 32'd1);
    next_cycle(); i_req = 1'b0; settle();
    check("starve_i_after_rvalid", 32'(i_rvalid), 32'd1);

    // Byte write then read back
    next_cycle();
    d_req = 1'b1; d_we = 4'b0010; d_addr = 32'h40; d_wdata = 32'hAABB_CCDD; settle();
    check("bw_d_gnt", 32'(d_gnt), 32'd1);
    check("bw_m_we", 32'(m_we), 32'b0010);
    check("bw_m_wdata", m_wdata, 32'hAABB_CCDD);
    check("bw_m_addr", m_addr, 32'h40);
    next_cycle(); d_we = 4'b0000; settle();
    check("bw_no_rvalid", 32'(d_rvalid), 32'd0);
    check("bw_read_gnt", 32'(d_gnt), 32'd1);
    next_cycle(); d_req = 1'b0; settle();
    check("bw_read_rvalid", 32'(d_rvalid), 32'd1);
    check("bw_read_rdata", d_rdata, 32'h0102_CC04);

    // Latency-3 read
    next_cycle(); d_req3 = 1'b1; d_we = 4'b0000; d_addr = 32'h200; settle();
    check("l3_d_gnt", 32'(d_gnt3), 32'd1);
    check("l3_m_req", 32'(m_req3), 32'd1);
    for (int k = 1; k < 3; k++) begin
      next_cycle(); d_req3 = 1'b0; settle();
      check($sformatf("l3_no_rvalid%0d", k), 32'(d_rvalid3), 32'd0);
    end
    next_cycle(); settle();
    check("l3_rvalid", 32'(d_rvalid3), 32'd1);
    check("l3_rdata", d_rdata3, 32'hDEAD_BEEF);

    // Reset one cycle after a latency-3 read grant
    next_cycle(); d_req3 = 1'b1; settle();
    check("rmid_d_gnt", 32'(d_gnt3), 32'd1);
    next_cycle(); reset3 = 1'b1; d_req3 = 1'b0; i_req3 = 1'b1; i_addr = 32'h100; settle();
    check("rmid_d_rvalid_a", 32'(d_rvalid3), 32'd0);
    check("rmid_i_gnt_a", 32'(i_gnt3), 32'd0);
    check("rmid_d_gnt_a", 32'(d_gnt3), 32'd0);
    check("rmid_m_req_a", 32'(m_req3), 32'd0);
    next_cycle(); settle();
    check("rmid_d_rvalid_b", 32'(d_rvalid3), 32'd0);
    check("rmid_i_gnt_b", 32'(i_gnt3), 32'd0);
    check("rmid_m_req_b", 32'(m_req3), 32'd0);
    check("rmid_d_rdata_clr", d_rdata3, 32'd0);
    next_cycle(); reset3 = 1'b0; settle();
    check("rmid_i_gnt_after", 32'(i_gnt3), 32'd1);
    check("rmid_m_addr_after", m_addr3, 32'h100);
    for (int k = 1; k <= 3; k++) begin
      next_cycle(); i_req3 = 1'b0; settle();
      check($sformatf("rmid_no_d_rvalid%0d", k), 32'(d_rvalid3), 32'd0);
      check($sformatf("rmid_i_rvalid%0d", k), 32'(i_rvalid3), (k == 3) ? 32'd1 : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
